clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider. Generalises the fixed divide-by-2/4 toggle chain to any ratio N in 2..2^WIDTH-1.
- Produces a 50%-duty divided clock for even N, and for odd N when ODD_DUTY_FIX=1.
- Also produces a one-cycle tick strobe in the clk_in domain for logic that must not use clk_out as a clock.
- Sits between the board clock and slow peripherals (UART baud, LED scan, debounce). Ratio changes are glitch-free and take effect only at period boundaries.

Parameters:
- WIDTH, 8, bit width of the divide ratio and internal counter.
- DEFAULT_DIV, 4, ratio in force after reset; must be 2..2^WIDTH-1.
- ODD_DUTY_FIX, 1, 1 = negedge half-cycle correction gives exact 50% duty on odd N; 0 = posedge only, with high time (N+1)/2 cycles.

Ports:
- clk_in  input  1  source clock.
- reset  input  1  reset, asynchronous, active-high. Clears all state.
- enable  input  1  run enable; when low the counter and clk_out freeze.
- div_val  input  WIDTH  requested divide ratio.
- div_load  input  1  one-cycle strobe; captures div_val as the pending ratio.
- clk_out  output  1  divided clock.
- tick  output  1  one clk_in-cycle pulse, coincident with each clk_out rising edge.
- div_active  output  WIDTH  ratio currently in force.
- cfg_err  output  1  sticky flag: an illegal ratio (0 or 1) was loaded. Cleared only by reset.

Behaviour:
- Reset (asynchronous):
  - cnt = DEFAULT_DIV-1; div_active = pending = DEFAULT_DIV.
  - clk_out = 0, tick = 0, cfg_err = 0; negedge flop = 0.
- Counter, on posedge clk_in with enable=1:
  - cnt == div_active-1 → cnt = 0 (wrap); otherwise cnt = cnt+1.
  - First enabled edge after reset wraps, so clk_out rises and tick=1 on that edge.
- Enable low:
  - cnt, pos flop and neg flop hold, so clk_out holds its level.
  - tick = 0.
  - Counting resumes from the held cnt with no extra or shortened phase.
- Pos flop: registered (cnt_next < H).
  - Even N: H = N/2.
  - Odd N: H = (N+1)/2.
- Neg flop: samples the pos flop on negedge clk_in, only when enable=1.
- clk_out selection:
  - Even N, or ODD_DUTY_FIX=0: clk_out = pos.
  - Odd N with ODD_DUTY_FIX=1: clk_out = pos AND neg, giving high time N/2 clk_in periods.
- tick: registered, 1 for exactly the cycle in which cnt_next == 0 and enable=1.
- Ratio update:
  - div_load=1 captures div_val into pending on that edge. A later load overwrites an earlier one; only the last value before the wrap applies.
  - div_active <= pending on the wrap edge, so the new N governs the period starting at that wrap. The current period always completes with the old N.
  - div_load on the wrap edge itself: that div_val is used directly at this wrap.
- Illegal values:
  - div_val of 0 or 1 is replaced by 2 in pending, and cfg_err is set to 1.
  - Values ≥ 2 pass through unchanged.
- Reset mid-period: clk_out goes to 0 immediately (asynchronous). The pending load is discarded and div_active returns to DEFAULT_DIV.
- Latency:
  - div_load to new ratio in effect: ≤ old N cycles (at the next wrap).
  - Reset release to first clk_out rise: 1 enabled edge.
- All arithmetic is unsigned WIDTH bits. H is computed from div_active, with no overflow for div_active ≤ 2^WIDTH-1.

Test Plan:
1. Reset with DEFAULT_DIV=4, enable=1 → clk_out = 0 during reset. After release: clk_out high 2 cycles, low 2 cycles, repeating. tick pulses every 4th clk_in cycle, aligned to the clk_out rise. div_active = 4.
2. Load 5 with ODD_DUTY_FIX=1 → after the next wrap: clk_out period 5 clk_in cycles, high 2.5 cycles measured at clk_in edges of both polarities; tick every 5 cycles. Repeat with ODD_DUTY_FIX=0 → high 3 cycles, low 2.
3. Mid-period ratio change: N=8, load 3 at cnt=2 → the current period finishes all 8 cycles. The next period is 3 cycles, with no runt pulse or double tick. A load of 6 then 10 before the wrap → only 10 is applied.
4. Enable deasserted for 7 cycles at cnt=1 with N=4 → clk_out and cnt frozen, tick=0. After re-enable, the remaining 2 cycles of the period complete, then normal 4-cycle periods.
5. Illegal load div_val=1 → cfg_err=1 on the next edge. After the wrap, div_active = 2 and clk_out toggles every cycle. cfg_err stays 1 until reset.
6. Reset pulse asserted mid-high phase with N=6 → clk_out = 0 asynchronously, div_active = DEFAULT_DIV. After release, the first enabled edge gives a clk_out rise and tick=1.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a glitch-free ratio update at
// period boundaries, a clk_in-domain tick strobe and optional odd-ratio duty fix.
module clk_div_prog #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = 4,
    parameter int ODD_DUTY_FIX = 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] half;
    logic             wrap;
    logic             illegal;
    logic             pos_q;
    logic             neg_q;

    always_comb begin
        illegal  = (div_val < MIN_DIV);
        load_val = illegal ? MIN_DIV : div_val;
        wrap     = enable && (cnt == div_active - 1'b1);
        // A load landing on the wrap edge bypasses pending and governs this new period.
        div_next = div_active;
        if (wrap)
            div_next = div_load ? load_val : pending;
        cnt_next = cnt;
        if (wrap)
            cnt_next = '0;
        else if (enable)
            cnt_next = cnt + 1'b1;
        // High phase length: N/2 for even N, (N+1)/2 for odd N, without overflow.
        half = (div_next >> 1) + {{(WIDTH-1){1'b0}}, div_next[0]};
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt        <= DEF_DIV - 1'b1;
            div_active <= DEF_DIV;
            pending    <= DEF_DIV;
            pos_q      <= 1'b0;
            tick       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            div_active <= div_next;
            tick       <= wrap;
            if (div_load) begin
                pending <= load_val;
                if (illegal)
                    cfg_err <= 1'b1;
            end
            if (enable)
                pos_q <= (cnt_next < half);
        end
    end

    // Half-cycle delayed copy; ANDed with pos_q it trims half a cycle off odd high phases.
    always_ff @(negedge clk_in or posedge reset) begin
        if (reset)
            neg_q <= 1'b0;
        else if (enable)
            neg_q <= pos_q;
    end

    always_comb begin
        clk_out = pos_q;
        if ((ODD_DUTY_FIX != 0) && div_active[0])
            clk_out = pos_q & neg_q;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: one instance with the odd-duty fix and one
// without, both checked against a period/phase reference model.
module tb_clk_div_prog;

    localparam int W   = 8;
    localparam int DEF = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [W-1:0] div_val;
    logic         div_load;
    logic         clk_out_a, tick_a, cfg_err_a;
    logic         clk_out_b, tick_b, cfg_err_b;
    logic [W-1:0] div_active_a, div_active_b;

    always #5 clk = ~clk;

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF), .ODD_DUTY_FIX(1)) dut_a (
        .clk_in(clk), .reset(reset), .enable(enable), .div_val(div_val),
        .div_load(div_load), .clk_out(clk_out_a), .tick(tick_a),
        .div_active(div_active_a), .cfg_err(cfg_err_a)
    );

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF), .ODD_DUTY_FIX(0)) dut_b (
        .clk_in(clk), .reset(reset), .enable(enable), .div_val(div_val),
        .div_load(div_load), .clk_out(clk_out_b), .tick(tick_b),
        .div_active(div_active_b), .cfg_err(cfg_err_b)
    );

    typedef struct {
        bit clk_a;
        bit clk_b;
    } neg_exp_t;

    typedef struct {
        bit tick;
        bit clk_a;
        bit clk_b;
        int div;
        bit err;
    } pos_exp_t;

    neg_exp_t nq[$];
    pos_exp_t pq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position within the current period, ratio, pending ratio.
    int m_p, m_n, m_pend;
    bit m_err;
    bit m_risen;   // an enabled falling edge has passed since the period began

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p     = DEF - 1;
        m_n     = DEF;
        m_pend  = DEF;
        m_err   = 1'b0;
        m_risen = 1'b0;
    endtask

    // Called a little after a rising edge; describes the coming falling and rising edges.
    task automatic step(input bit en, input bit ld, input int val);
        neg_exp_t ne;
        pos_exp_t pe;
        int  h, lv;
        bit  wrap;
        enable   = en;
        div_load = ld;
        div_val  = W'(val);

        h = (m_n + 1) / 2;
        ne.clk_b = (m_p < h);
        if (m_n % 2 == 1)
            ne.clk_a = (m_p < h) && (en || m_risen);
        else
            ne.clk_a = (m_p < h);
        nq.push_back(ne);
        if (en) m_risen = 1'b1;

        wrap = en && (m_p == m_n - 1);
        lv = (val < 2) ? 2 : val;
        if (ld && val < 2) m_err = 1'b1;
        if (wrap) begin
            m_n     = ld ? lv : m_pend;
            m_p     = 0;
            m_risen = 1'b0;
        end else if (en) begin
            m_p++;
        end
        if (ld) m_pend = lv;

        h = (m_n + 1) / 2;
        pe.tick  = wrap;
        pe.clk_b = (m_p < h);
        pe.clk_a = (m_n % 2 == 1) ? ((m_p < h) && m_risen) : (m_p < h);
        pe.div   = m_n;
        pe.err   = m_err;
        pq.push_back(pe);

        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (m_p != target && guard < 300) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        if (m_p != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_until: phase %0d never reached, stuck at %0d", target, m_p);
        end
    endtask

    // Asynchronous reset pulse in the middle of a clk_in cycle.
    task automatic mid_reset();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_clk_out_a", clk_out_a, 0);
        chk("rst_clk_out_b", clk_out_b, 0);
        chk("rst_div_active", div_active_a, DEF);
        chk("rst_tick", tick_a, 0);
        chk("rst_cfg_err", cfg_err_a, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        neg_exp_t e;
        #1;
        if (nq.size() > 0) begin
            e = nq.pop_front();
            chk("clk_out_a_fall", clk_out_a, e.clk_a);
            chk("clk_out_b_fall", clk_out_b, e.clk_b);
        end
    end

    always @(posedge clk) begin
        pos_exp_t e;
        #1;
        if (pq.size() > 0) begin
            e = pq.pop_front();
            chk("tick_a", tick_a, e.tick);
            chk("tick_b", tick_b, e.tick);
            chk("clk_out_a_rise", clk_out_a, e.clk_a);
            chk("clk_out_b_rise", clk_out_b, e.clk_b);
            chk("div_active_a", div_active_a, e.div);
            chk("div_active_b", div_active_b, e.div);
            chk("cfg_err_a", cfg_err_a, e.err);
            chk("cfg_err_b", cfg_err_b, e.err);
        end
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        #3;
        chk("init_clk_out", clk_out_a, 0);
        chk("init_tick", tick_a, 0);
        chk("init_div_active", div_active_a, DEF);
        chk("init_cfg_err", cfg_err_a, 0);
        #4;
        reset = 1'b0;
        model_reset();

        // Default ratio straight out of reset
        run(12);
        // Odd ratio on both duty modes
        step(1'b1, 1'b1, 5);
        run(16);
        // Mid-period change: N=8 then 3 loaded at phase 2
        step(1'b1, 1'b1, 8);
        run_until(0);
        run_until(2);
        step(1'b1, 1'b1, 3);
        run_until(0);
        run(7);
        // Only the last of several loads before a wrap applies
        step(1'b1, 1'b1, 6);
        step(1'b1, 1'b1, 10);
        run_until(0);
        run(22);
        // Freeze at phase 1 with N=4
        step(1'b1, 1'b1, 4);
        run_until(0);
        run_until(1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0);
        run(12);
        // Freeze right after a wrap with an odd ratio
        step(1'b1, 1'b1, 7);
        run_until(0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        run(16);
        // Illegal ratio
        step(1'b1, 1'b1, 1);
        run(10);
        step(1'b1, 1'b1, 0);
        run(6);
        // Reset in the high phase of N=6
        step(1'b1, 1'b1, 6);
        run_until(0);
        run_until(1);
        mid_reset();
        run(10);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit en, ld;
            int v;
            en = ($urandom_range(0, 9) < 8);
            ld = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            step(en, ld, v);
        end

        if (nq.size() != 0 || pq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", nq.size(), pq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
